// File: rtl/z80_mem_responder_pkg.sv
// Shared types for the Z80 memory responder: FSM states, bus cycle kinds, write-log entry.
// No logic; latency n/a.
// Backpressure n/a.
package z80_mem_responder_pkg;

    localparam int AW_MAX = 16;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_t;

    typedef enum logic [1:0] {KIND_RD, KIND_WR, KIND_INTA} kind_t;

    typedef struct packed {
        logic [AW_MAX-1:0] addr;
        logic [7:0]        data;
    } log_entry_t;

    localparam int LOG_W = $bits(log_entry_t);

endpackage

// File: rtl/z80_mem_responder_if.sv
// Z80 CPU bus bundle: address/data plus active-low strobes, read data and wait request.
// Wires only, no latency.
// Backpressure via wait_n driven by the slave side.
interface z80_mem_responder_if #(
    parameter int AW = 16
) ();
    logic [AW-1:0] a;
    logic [7:0]    dout;
    logic          m1_n;
    logic          mreq_n;
    logic          iorq_n;
    logic          rd_n;
    logic          wr_n;
    logic          rfsh_n;
    logic [7:0]    di;
    logic          wait_n;

    modport master (
        output a, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        input  di, wait_n
    );

    modport slave (
        input  a, dout, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n,
        output di, wait_n
    );
endinterface

// File: rtl/z80_mem_responder_wr_log_fifo.sv
// Generic DEPTH x W FIFO with first-word fall-through head and sticky overflow flag.
// Head visible the cycle after push; pop takes effect at the clock edge.
// Push when full without a same-cycle pop is dropped and sets ovf_o until reset.
module wr_log_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic         full_o,
    output logic         ovf_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ovf_q;
    logic          empty, push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
            if (push_i && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) store_q[wr_ptr_q] <= push_dat_i;
    end

    assign vld_o = !empty;
    assign dat_o = store_q[rd_ptr_q];
    assign ovf_o = ovf_q;
endmodule

// File: rtl/z80_mem_responder.sv
// Memory target for a Z80 core: serves read/write/INTA cycles from a byte array and logs writes.
// Read data on di cfg_wait+1 cycles after the start edge; wait_n low for exactly cfg_wait cycles.
// CPU is stalled with wait_n; the write log drops entries when full and flags log_ovf.
module z80_mem_responder
    import z80_mem_responder_pkg::*;
#(
    parameter int         AW        = 16,
    parameter int         LOG_DEPTH = 8,
    parameter logic [7:0] INTA_VEC  = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    z80_mem_responder_if.slave   bus,
    input  logic [3:0]           cfg_wait,
    input  logic                 ld_en,
    input  logic [AW-1:0]        ld_addr,
    input  logic [7:0]           ld_data,
    output logic                 log_valid,
    output logic [AW-1:0]        log_addr,
    output logic [7:0]           log_data,
    input  logic                 log_ready,
    output logic                 log_ovf
);
    logic [7:0]    mem [1 << AW];

    state_t        state_q;
    kind_t         kind_q;
    logic [AW-1:0] a_q;
    logic [3:0]    cnt_q;
    logic [7:0]    di_q;
    logic          wait_n_q;

    logic          mem_start, inta_start, commit, log_full;
    log_entry_t    push_entry, head_entry;

    // Refresh cycles also drive mreq_n low; rfsh_n keeps them out.
    assign mem_start  = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n);
    assign inta_start = !bus.m1_n && !bus.iorq_n;
    assign commit     = reset_n && (state_q == ACCESS) && (kind_q == KIND_WR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            kind_q   <= KIND_RD;
            a_q      <= '0;
            cnt_q    <= '0;
            di_q     <= 8'hFF;
            wait_n_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_start || inta_start) begin
                        a_q    <= bus.a;
                        cnt_q  <= cfg_wait;
                        kind_q <= mem_start ? (!bus.wr_n ? KIND_WR : KIND_RD) : KIND_INTA;
                        if (cfg_wait != 4'd0) begin
                            state_q  <= WAIT;
                            wait_n_q <= 1'b0;
                        end else begin
                            state_q  <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q  <= ACCESS;
                        wait_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACCESS: begin
                    case (kind_q)
                        KIND_RD:   di_q <= mem[a_q];
                        KIND_INTA: di_q <= INTA_VEC;
                        default:   di_q <= di_q;
                    endcase
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (bus.mreq_n && bus.iorq_n) begin
                        state_q <= IDLE;
                        di_q    <= 8'hFF;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus commit is written last so it wins over a same-address backdoor load.
    always_ff @(posedge clk) begin
        if (ld_en)  mem[ld_addr] <= ld_data;
        if (commit) mem[a_q]     <= bus.dout;
    end

    assign push_entry.addr = AW_MAX'(a_q);
    assign push_entry.data = bus.dout;

    wr_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .W     (LOG_W)
    ) u_wr_log_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (commit),
        .push_dat_i (push_entry),
        .pop_i      (log_ready),
        .vld_o      (log_valid),
        .dat_o      (head_entry),
        .full_o     (log_full),
        .ovf_o      (log_ovf)
    );

    assign log_addr   = head_entry.addr[AW-1:0];
    assign log_data   = head_entry.data;
    assign bus.di     = di_q;
    assign bus.wait_n = wait_n_q;
endmodule

// File: tb/tb_z80_mem_responder.sv
// Directed bench for z80_mem_responder: bus cycles, wait states, write log, refresh/INTA, reset.
// Drives and samples on the falling edge; all expectations are hand-computed constants.
module tb_z80_mem_responder;
    import z80_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  cfg_wait;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        log_valid;
    logic [15:0] log_addr;
    logic [7:0]  log_data;
    logic        log_ready;
    logic        log_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int wait_low = 0;
    logic mon_en = 1'b0;
    logic [7:0] rd;

    z80_mem_responder_if #(.AW(16)) bus ();

    z80_mem_responder #(.AW(16), .LOG_DEPTH(8), .INTA_VEC(8'hFF)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .cfg_wait  (cfg_wait),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .log_valid (log_valid),
        .log_addr  (log_addr),
        .log_data  (log_data),
        .log_ready (log_ready),
        .log_ovf   (log_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && bus.wait_n === 1'b0) wait_low++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
        bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.rfsh_n = 1'b1;
    endtask

    task automatic backdoor(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.a = addr; bus.dout = data; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
        repeat (int'(cfg_wait) + 2) @(negedge clk);
        bus_idle();
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [15:0] addr, input logic m1, output logic [7:0] data);
        @(negedge clk);
        bus.a = addr; bus.m1_n = !m1; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        repeat (int'(cfg_wait) + 2) @(negedge clk);
        data = bus.di;
        bus_idle();
        @(negedge clk);
    endtask

    // Called at a falling edge; checks the head then pops it on the next rising edge.
    task automatic pop_check(input string tag, input logic [15:0] ea, input logic [7:0] ed);
        check_eq({tag, "_vld"}, 32'(log_valid), 32'd1);
        check_eq({tag, "_addr"}, 32'(log_addr), 32'(ea));
        check_eq({tag, "_data"}, 32'(log_data), 32'(ed));
        log_ready = 1'b1;
        @(negedge clk);
        log_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cfg_wait = 4'd0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        log_ready = 1'b0; bus.a = '0; bus.dout = '0;
        bus_idle();
        repeat (3) @(negedge clk);
        check_eq("rst_di", 32'(bus.di), 32'hFF);
        check_eq("rst_wait_n", 32'(bus.wait_n), 32'd1);
        check_eq("rst_log_valid", 32'(log_valid), 32'd0);
        check_eq("rst_log_ovf", 32'(log_ovf), 32'd0);
        reset_n = 1'b1;

        // 1: fetch FD 02, then write A=56 to (BC)=0134 with no wait states
        backdoor(16'h0000, 8'hFD);
        backdoor(16'h0001, 8'h02);
        backdoor(16'h0002, 8'h00);
        mon_en = 1'b1;
        cpu_read(16'h0000, 1'b1, rd);
        check_eq("t1_fetch0", 32'(rd), 32'hFD);
        cpu_read(16'h0001, 1'b1, rd);
        check_eq("t1_fetch1", 32'(rd), 32'h02);
        cpu_write(16'h0134, 8'h56);
        mon_en = 1'b0;
        check_eq("t1_wait_low", 32'(wait_low), 32'd0);
        check_eq("t1_ovf", 32'(log_ovf), 32'd0);
        cpu_read(16'h0134, 1'b0, rd);
        check_eq("t1_mem", 32'(rd), 32'h56);
        pop_check("t1_log", 16'h0134, 8'h56);
        check_eq("t1_log_empty", 32'(log_valid), 32'd0);

        // 2: two wait states on a read of backdoor-loaded data
        backdoor(16'h1234, 8'hA5);
        cfg_wait = 4'd2;
        @(negedge clk);
        bus.a = 16'h1234; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        @(negedge clk);
        check_eq("t2_wait1", 32'(bus.wait_n), 32'd0);
        @(negedge clk);
        check_eq("t2_wait2", 32'(bus.wait_n), 32'd0);
        @(negedge clk);
        check_eq("t2_wait_end", 32'(bus.wait_n), 32'd1);
        check_eq("t2_di_early", 32'(bus.di), 32'hFF);
        @(negedge clk);
        check_eq("t2_di", 32'(bus.di), 32'hA5);
        bus_idle();
        @(negedge clk);
        check_eq("t2_di_idle", 32'(bus.di), 32'hFF);
        cfg_wait = 4'd0;

        // 3: nine writes into an eight-entry log with nobody draining
        for (int i = 0; i < 9; i++) cpu_write(16'h2000 + 16'(i), 8'h10 + 8'(i));
        check_eq("t3_ovf", 32'(log_ovf), 32'd1);
        for (int i = 0; i < 8; i++) pop_check($sformatf("t3_pop%0d", i), 16'h2000 + 16'(i), 8'h10 + 8'(i));
        check_eq("t3_drained", 32'(log_valid), 32'd0);
        check_eq("t3_ovf_sticky", 32'(log_ovf), 32'd1);
        cpu_read(16'h2008, 1'b0, rd);
        check_eq("t3_dropped_mem", 32'(rd), 32'h18);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t3_rst_ovf", 32'(log_ovf), 32'd0);
        reset_n = 1'b1;
        cpu_read(16'h0134, 1'b0, rd);
        check_eq("t3_mem_kept", 32'(rd), 32'h56);

        // 4: commit into a full log while the head is popped in the same cycle
        for (int i = 0; i < 8; i++) cpu_write(16'h3000 + 16'(i), 8'h30 + 8'(i));
        check_eq("t4_full_ovf", 32'(log_ovf), 32'd0);
        @(negedge clk);
        bus.a = 16'h3100; bus.dout = 8'h99; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
        @(negedge clk);
        log_ready = 1'b1;
        @(negedge clk);
        log_ready = 1'b0;
        check_eq("t4_ovf", 32'(log_ovf), 32'd0);
        bus_idle();
        @(negedge clk);
        for (int i = 1; i < 8; i++) pop_check($sformatf("t4_pop%0d", i), 16'h3000 + 16'(i), 8'h30 + 8'(i));
        pop_check("t4_tail", 16'h3100, 8'h99);
        check_eq("t4_drained", 32'(log_valid), 32'd0);

        // 5: refresh and plain I/O are ignored; INTA runs a full cycle returning FF
        @(negedge clk);
        bus.a = 16'h0000; bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; bus.rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t5_rfsh_st%0d", i), 32'(dut.state_q), 32'(IDLE));
        end
        bus_idle();
        @(negedge clk);
        bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
        @(negedge clk);
        check_eq("t5_io_st", 32'(dut.state_q), 32'(IDLE));
        bus_idle();
        cfg_wait = 4'd1;
        @(negedge clk);
        bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
        @(negedge clk);
        check_eq("t5_inta_wait", 32'(bus.wait_n), 32'd0);
        @(negedge clk);
        check_eq("t5_inta_wait_end", 32'(bus.wait_n), 32'd1);
        @(negedge clk);
        check_eq("t5_inta_st", 32'(dut.state_q), 32'(HOLD));
        check_eq("t5_inta_di", 32'(bus.di), 32'hFF);
        bus_idle();
        @(negedge clk);
        check_eq("t5_log_empty", 32'(log_valid), 32'd0);
        cfg_wait = 4'd0;
        cpu_read(16'h0000, 1'b0, rd);
        check_eq("t5_mem0", 32'(rd), 32'hFD);

        // 6: reset lands while a write is still stalled in WAIT
        backdoor(16'h4000, 8'h11);
        cfg_wait = 4'd5;
        @(negedge clk);
        bus.a = 16'h4000; bus.dout = 8'h77; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
        @(negedge clk);
        check_eq("t6_wait", 32'(bus.wait_n), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("t6_wait_n", 32'(bus.wait_n), 32'd1);
        check_eq("t6_st", 32'(dut.state_q), 32'(IDLE));
        check_eq("t6_log", 32'(log_valid), 32'd0);
        reset_n = 1'b1;
        bus_idle();
        cfg_wait = 4'd0;
        @(negedge clk);
        cpu_read(16'h4000, 1'b0, rd);
        check_eq("t6_no_commit", 32'(rd), 32'h11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
